// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: channel state encodings and
// the default timing for the 50 MHz board clock.
package button_event_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  localparam int unsigned DEF_LONG_CYCLES   = 32'd50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 32'd10_000_000;
  localparam int unsigned DEF_CNT_W         = 32'd26;

endpackage

// File: rtl/button_event_channel.sv
// One button channel: IDLE/DOWN/HELD FSM with a cycle counter that turns a
// debounced level into registered press/release/long-press/repeat pulses.
module button_event_channel
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic Clk,
  input  logic Rst,
  input  logic btn,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam bit               REPEAT_EN   = (REPEAT_CYCLES != 32'd0);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_EN ? CNT_W'(REPEAT_CYCLES - 32'd1)
                                                       : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             press_r, release_r, long_r, repeat_r, held_r;
  logic             press_nxt_s, release_nxt_s, long_nxt_s, repeat_nxt_s, held_nxt_s;

  // Next-state, counter and pulse decode; release wins over a due long/repeat
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    long_nxt_s    = 1'b0;
    repeat_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (btn) begin
          state_nxt_s = ST_DOWN;
          press_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DOWN: begin
        if (!btn) begin
          state_nxt_s   = ST_IDLE;
          cnt_nxt_s     = CNT_ZERO;
          release_nxt_s = 1'b1;
        end else if (cnt_r == LONG_LAST) begin
          state_nxt_s = ST_HELD;
          cnt_nxt_s   = CNT_ZERO;
          long_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!btn) begin
          state_nxt_s   = ST_IDLE;
          cnt_nxt_s     = CNT_ZERO;
          release_nxt_s = 1'b1;
        end else if (!REPEAT_EN) begin
          cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == REPEAT_LAST) begin
          cnt_nxt_s    = CNT_ZERO;
          repeat_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
    // Held stays up through the Release cycle itself
    held_nxt_s = (state_nxt_s != ST_IDLE) || release_nxt_s;
  end

  // State, counter and output pulse registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      held_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
      long_r    <= long_nxt_s;
      repeat_r  <= repeat_nxt_s;
      held_r    <= held_nxt_s;
    end
  end

  assign press         = press_r;
  assign release_pulse = release_r;
  assign long_press    = long_r;
  assign repeat_pulse  = repeat_r;
  assign held          = held_r;

endmodule

// File: rtl/button_event_decoder.sv
// Converts WIDTH debounced button levels into per-channel press, release,
// long-press, auto-repeat pulses and a held level; channels are independent.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned WIDTH         = 32'd4,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Input,
  output logic [WIDTH-1:0] Press,
  output logic [WIDTH-1:0] Release,
  output logic [WIDTH-1:0] LongPress,
  output logic [WIDTH-1:0] Repeat,
  output logic [WIDTH-1:0] Held
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    button_event_channel #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .Clk          (Clk),
      .Rst          (Rst),
      .btn          (Input[gi]),
      .press        (Press[gi]),
      .release_pulse(Release[gi]),
      .long_press   (LongPress[gi]),
      .repeat_pulse (Repeat[gi]),
      .held         (Held[gi])
    );
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event_decoder;

  logic       Clk;
  logic       Rst;
  logic [3:0] Input;
  logic [3:0] Press, Release, LongPress, Repeat, Held;

  int checks = 0;
  int errors = 0;

  button_event_decoder #(
    .WIDTH(4), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Input(Input),
    .Press(Press), .Release(Release), .LongPress(LongPress),
    .Repeat(Repeat), .Held(Held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got P/R/L/Rp/H=%05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [19:0] outs();
    return {Press, Release, LongPress, Repeat, Held};
  endfunction

  task automatic cycle_and_check(input string tag, input logic [3:0] p, input logic [3:0] r,
                                 input logic [3:0] l, input logic [3:0] rp, input logic [3:0] h);
    tick();
    check_val(tag, outs(), {p, r, l, rp, h});
  endtask

  initial begin
    logic [3:0] m;
    // 1: reset behaviour
    Rst   = 1'b0;
    Input = 4'hF;
    tick();
    check_val("reset_hold", outs(), 20'h00000);
    Rst = 1'b1;
    cycle_and_check("press_after_rst", 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
    #2 Rst = 1'b0;
    #1 check_val("async_clear", outs(), 20'h00000);
    tick();
    Input = 4'h0;
    Rst   = 1'b1;
    for (int i = 0; i < 20; i++) cycle_and_check("idle_after_rst", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    // 2: short press on ch0, 5 cycles
    m = 4'b0001;
    for (int j = 0; j <= 6; j++) begin
      Input = (j < 5) ? m : 4'h0;
      cycle_and_check($sformatf("short_ch0_c%0d", j), (j == 0) ? m : 4'h0, (j == 5) ? m : 4'h0,
                      4'h0, 4'h0, (j <= 5) ? m : 4'h0);
    end

    // 3: long hold on ch1, 20 cycles; repeat due at 20 loses to release
    m = 4'b0010;
    for (int j = 0; j <= 21; j++) begin
      Input = (j < 20) ? m : 4'h0;
      cycle_and_check($sformatf("long_ch1_c%0d", j), (j == 0) ? m : 4'h0, (j == 20) ? m : 4'h0,
                      (j == 8) ? m : 4'h0, (j == 12 || j == 16) ? m : 4'h0,
                      (j <= 20) ? m : 4'h0);
    end

    // 4: ch2 falls exactly when LongPress would fire
    m = 4'b0100;
    for (int j = 0; j <= 9; j++) begin
      Input = (j < 8) ? m : 4'h0;
      cycle_and_check($sformatf("collide_ch2_c%0d", j), (j == 0) ? m : 4'h0, (j == 8) ? m : 4'h0,
                      4'h0, 4'h0, (j <= 8) ? m : 4'h0);
    end

    // 5: channel independence
    Input = 4'b1010;
    cycle_and_check("indep_a", 4'b1010, 4'b0000, 4'h0, 4'h0, 4'b1010);
    Input = 4'b0101;
    cycle_and_check("indep_b", 4'b0101, 4'b1010, 4'h0, 4'h0, 4'b1111);
    Input = 4'b0000;
    cycle_and_check("indep_c", 4'b0000, 4'b0101, 4'h0, 4'h0, 4'b0101);
    cycle_and_check("indep_d", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    // 6: reset while ch3 is in HELD, button kept down through reset
    m = 4'b1000;
    Input = m;
    for (int j = 0; j <= 10; j++)
      cycle_and_check($sformatf("mid_ch3_c%0d", j), (j == 0) ? m : 4'h0, 4'h0,
                      (j == 8) ? m : 4'h0, 4'h0, m);
    #2 Rst = 1'b0;
    #1 check_val("mid_async_clear", outs(), 20'h00000);
    tick();
    check_val("mid_in_reset", outs(), 20'h00000);
    Rst = 1'b1;
    for (int j = 0; j <= 9; j++)
      cycle_and_check($sformatf("fresh_ch3_c%0d", j), (j == 0) ? m : 4'h0, 4'h0,
                      (j == 8) ? m : 4'h0, 4'h0, m);
    Input = 4'h0;
    cycle_and_check("fresh_ch3_rel", 4'h0, m, 4'h0, 4'h0, m);
    cycle_and_check("fresh_ch3_idle", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
